// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encodings and datapath width
// for the 8-bit ALU and its shifter.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int SHAMT_W = 3;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_XOR  = 4'b0001,
    OP_ORR  = 4'b0010,
    OP_BNE  = 4'b0101,
    OP_SLL  = 4'b0110,
    OP_SRL  = 4'b0111,
    OP_AND  = 4'b1000,
    OP_RXOR = 4'b1001,
    OP_SUB  = 4'b1100,
    OP_BEQ  = 4'b1101
  } op_t;

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: logical left/right shift of one operand
// by an 8-bit amount; amounts of DATA_W or more give 0.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_amt,
  input  logic              i_dir,
  output logic [DATA_W-1:0] o_res
);

  logic              w_in_range;
  logic [SHAMT_W-1:0] w_sh;

  assign w_in_range = (i_amt < DATA_W[DATA_W-1:0]);
  assign w_sh = i_amt[SHAMT_W-1:0];

  // direction 1 shifts right, 0 shifts left; zero fill both ways
  always_comb begin
    o_res = '0;
    if (w_in_range) begin
      if (i_dir) o_res = i_a >> w_sh;
      else       o_res = i_a << w_sh;
    end
  end

endmodule

// File: rtl/alu.sv
// alu: combinational 8-bit result, branch and zero outputs,
// plus a carry/borrow flag registered on ADD/SUB.
module alu
  import alu_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] InputA,
  input  logic [DATA_W-1:0] InputB,
  input  logic [3:0]        OP,
  output logic [DATA_W-1:0] Out,
  output logic              jump,
  output logic              Zero,
  output logic              Carry
);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_diff;
  logic              w_borrow;
  logic              w_eq;
  logic [DATA_W-1:0] w_shift;
  logic [DATA_W-1:0] w_out;
  logic              w_jump;
  logic              r_carry;

  assign w_sum    = {1'b0, InputA} + {1'b0, InputB};
  assign w_diff   = InputA - InputB;
  assign w_borrow = (InputA < InputB);
  assign w_eq     = (InputA == InputB);

  // SLL and SRL differ only in OP[0]
  alu_shifter u_shifter (
    .i_a   (InputA),
    .i_amt (InputB),
    .i_dir (OP[0]),
    .o_res (w_shift)
  );

  // opcode decode; undefined opcodes fall to zero result, no jump
  always_comb begin
    w_out  = '0;
    w_jump = 1'b0;
    case (OP)
      OP_ADD:  w_out = w_sum[DATA_W-1:0];
      OP_XOR:  w_out = InputA ^ InputB;
      OP_ORR:  w_out = InputA | InputB;
      OP_BNE: begin
        w_out  = {{(DATA_W-1){1'b0}}, ~w_eq};
        w_jump = ~w_eq;
      end
      OP_SLL:  w_out = w_shift;
      OP_SRL:  w_out = w_shift;
      OP_AND:  w_out = InputA & InputB;
      OP_RXOR: w_out = {{(DATA_W-1){1'b0}}, ^{InputA, InputB}};
      OP_SUB:  w_out = w_diff;
      OP_BEQ: begin
        w_out  = {{(DATA_W-1){1'b0}}, w_eq};
        w_jump = w_eq;
      end
      default: begin
        w_out  = '0;
        w_jump = 1'b0;
      end
    endcase
  end

  // carry/borrow flag: loads on ADD/SUB, holds otherwise
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)           r_carry <= 1'b0;
    else if (OP == OP_ADD)  r_carry <= w_sum[DATA_W];
    else if (OP == OP_SUB)  r_carry <= w_borrow;
  end

  assign Out   = w_out;
  assign jump  = w_jump;
  assign Zero  = (w_out == '0);
  assign Carry = r_carry;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed and random checks of the ALU against
// an arithmetic reference model.
module tb_alu;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [7:0] InputA = '0;
  logic [7:0] InputB = '0;
  logic [3:0] OP = '0;
  logic [7:0] Out;
  logic       jump;
  logic       Zero;
  logic       Carry;

  int checks = 0;
  int errors = 0;
  logic m_carry = 1'b0;

  always #5 Clk = ~Clk;

  alu dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .InputA  (InputA),
    .InputB  (InputB),
    .OP      (OP),
    .Out     (Out),
    .jump    (jump),
    .Zero    (Zero),
    .Carry   (Carry)
  );

  function automatic int m_out(int op, int a, int b);
    case (op)
      0:  return (a + b) % 256;
      1:  return a ^ b;
      2:  return a | b;
      5:  return (a != b) ? 1 : 0;
      6:  return (b >= 8) ? 0 : (a * (1 << b)) % 256;
      7:  return (b >= 8) ? 0 : a / (1 << b);
      8:  return a & b;
      9:  return ($countones(a) + $countones(b)) % 2;
      12: return (a - b + 256) % 256;
      13: return (a == b) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_jump(int op, int a, int b);
    if (op == 5)  return a != b;
    if (op == 13) return a == b;
    return 0;
  endfunction

  function automatic logic m_next_carry(int op, int a, int b,
                                        logic cur);
    if (op == 0)  return (a + b) > 255;
    if (op == 12) return a < b;
    return cur;
  endfunction

  task automatic drive(int op, int a, int b);
    OP = op[3:0];
    InputA = a[7:0];
    InputB = b[7:0];
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (Carry !== 1'b0) begin
      errors++;
      $display("FAIL reset_carry got %b want 0", Carry);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    m_carry = 1'b0;
  endtask

  task automatic test_directed;
    int v[18][5] = '{
      '{0,  'h01, 'h01, 'h02, 0},
      '{0,  'hFF, 'h01, 'h00, 0},
      '{8,  'h04, 'h01, 'h00, 0},
      '{6,  'h01, 'h07, 'h80, 0},
      '{6,  'h01, 'h08, 'h00, 0},
      '{7,  'h80, 'h07, 'h01, 0},
      '{7,  'h80, 'hFF, 'h00, 0},
      '{9,  'h51, 'h07, 'h00, 0},
      '{9,  'h51, 'h44, 'h01, 0},
      '{5,  'h51, 'h44, 'h01, 1},
      '{5,  'h51, 'h51, 'h00, 0},
      '{13, 'h51, 'h44, 'h00, 0},
      '{13, 'h51, 'h51, 'h01, 1},
      '{12, 'h03, 'h05, 'hFE, 0},
      '{3,  'h12, 'h34, 'h00, 0},
      '{10, 'hAA, 'h55, 'h00, 0},
      '{15, 'hFF, 'hFF, 'h00, 0},
      '{4,  'h00, 'h01, 'h00, 0}
    };
    for (int i = 0; i < 18; i++) begin
      @(negedge Clk);
      drive(v[i][0], v[i][1], v[i][2]);
      #1;
      checks++;
      if (Out !== v[i][3][7:0] || jump !== v[i][4][0] ||
          Zero !== (v[i][3] == 0)) begin
        errors++;
        $display("FAIL dir%0d op=%0d out=%h j=%b z=%b want %h %0d",
                 i, v[i][0], Out, jump, Zero, v[i][3], v[i][4]);
      end
      @(posedge Clk);
      m_carry = m_next_carry(v[i][0], v[i][1], v[i][2], m_carry);
    end
  endtask

  task automatic test_carry;
    @(negedge Clk);
    drive(0, 'hFF, 'h01);
    @(posedge Clk);
    #1;
    checks++;
    if (Carry !== 1'b1) begin
      errors++;
      $display("FAIL add_carry got %b want 1", Carry);
    end
    @(negedge Clk);
    drive(12, 'h05, 'h03);
    @(posedge Clk);
    #1;
    checks++;
    if (Carry !== 1'b0) begin
      errors++;
      $display("FAIL sub_noborrow got %b want 0", Carry);
    end
    @(negedge Clk);
    drive(12, 'h03, 'h05);
    @(posedge Clk);
    #1;
    checks++;
    if (Carry !== 1'b1) begin
      errors++;
      $display("FAIL sub_borrow got %b want 1", Carry);
    end
    @(negedge Clk);
    drive(1, 'h00, 'h00);
    @(posedge Clk);
    #1;
    checks++;
    if (Carry !== 1'b1) begin
      errors++;
      $display("FAIL xor_hold got %b want 1", Carry);
    end
    @(negedge Clk);
    drive(0, 'hFF, 'h01);
    #2;
    drive(0, 'h01, 'h01);
    @(posedge Clk);
    #1;
    checks++;
    if (Carry !== 1'b0) begin
      errors++;
      $display("FAIL edge_sample got %b want 0", Carry);
    end
    m_carry = 1'b0;
  endtask

  task automatic test_reset_mid;
    @(negedge Clk);
    drive(12, 'h03, 'h05);
    @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    checks++;
    if (Carry !== 1'b0 || Out !== 8'hFE) begin
      errors++;
      $display("FAIL async_reset carry=%b out=%h want 0 fe",
               Carry, Out);
    end
    @(posedge Clk);
    #1;
    checks++;
    if (Carry !== 1'b0) begin
      errors++;
      $display("FAIL held_in_reset got %b want 0", Carry);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    checks++;
    if (Carry !== 1'b1) begin
      errors++;
      $display("FAIL after_release got %b want 1", Carry);
    end
    m_carry = 1'b1;
  endtask

  task automatic test_random;
    int op, a, b, eo;
    bit ej;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      op = $urandom_range(0, 15);
      a = $urandom_range(0, 255);
      if ($urandom_range(0, 1) == 1) b = $urandom_range(0, 10);
      else b = $urandom_range(0, 255);
      if ($urandom_range(0, 7) == 0) b = a;
      drive(op, a, b);
      eo = m_out(op, a, b);
      ej = m_jump(op, a, b);
      #1;
      checks++;
      if (Out !== eo[7:0] || jump !== ej || Zero !== (eo == 0)) begin
        errors++;
        $display("FAIL rnd%0d op=%0d a=%h b=%h out=%h j=%b z=%b want %h %b",
                 i, op, a, b, Out, jump, Zero, eo[7:0], ej);
      end
      @(posedge Clk);
      m_carry = m_next_carry(op, a, b, m_carry);
      #1;
      checks++;
      if (Carry !== m_carry) begin
        errors++;
        $display("FAIL rnd_carry%0d op=%0d got %b want %b",
                 i, op, Carry, m_carry);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_carry;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
